// File: rtl/asp_tx.sv
// ASP transmit path: parity-checks host words, sends {data, tag} frames and retries until ACK.
// Define ASP_TX_ODD_PARITY_EN to check odd instead of even parity on host words.
module asp_tx #(
    parameter int                  data_size   = 32,
    parameter int                  tag_size    = 8,
    parameter logic [tag_size-1:0] tag_value   = 8'hAB,
    parameter int                  ack_timeout = 16,
    parameter int                  max_retries = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          data_parity_ready_in,
    input  logic [data_size:0]            data_parity_in,
    input  logic                          network_ACK_in,
    output logic                          host_ready_out,
    output logic                          parity_error_out,
    output logic                          tx_fail_out,
    output logic                          network_data_ready_out,
    output logic [data_size+tag_size-1:0] network_data_tag_out
);

`ifdef ASP_TX_ODD_PARITY_EN
    localparam logic parity_target = 1'b1;
`else
    localparam logic parity_target = 1'b0;
`endif

    localparam logic [7:0] timeout_last = 8'(ack_timeout - 1);
    localparam logic [3:0] retry_limit  = 4'(max_retries);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK
    } state_t;

    state_t     state;
    logic [7:0] timeout_count;
    logic [3:0] retry_count;
    logic       parity_ok;

    assign parity_ok = ((^data_parity_in) == parity_target);

    // Pulse outputs default low every cycle; the FSM raises them for exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                  <= IDLE;
            host_ready_out         <= 1'b1;
            parity_error_out       <= 1'b0;
            tx_fail_out            <= 1'b0;
            network_data_ready_out <= 1'b0;
            network_data_tag_out   <= '0;
            timeout_count          <= '0;
            retry_count            <= '0;
        end else begin
            parity_error_out       <= 1'b0;
            tx_fail_out            <= 1'b0;
            network_data_ready_out <= 1'b0;
            case (state)
                IDLE: begin
                    host_ready_out <= 1'b1;
                    if (data_parity_ready_in) begin
                        if (parity_ok) begin
                            network_data_tag_out   <= {data_parity_in[data_size-1:0], tag_value};
                            retry_count            <= '0;
                            network_data_ready_out <= 1'b1;
                            host_ready_out         <= 1'b0;
                            state                  <= SEND;
                        end else begin
                            parity_error_out <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    timeout_count <= '0;
                    state         <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // ACK is checked first so it wins over a timeout expiring in the same cycle.
                    if (network_ACK_in) begin
                        host_ready_out <= 1'b1;
                        state          <= IDLE;
                    end else if (timeout_count == timeout_last) begin
                        if (retry_count < retry_limit) begin
                            retry_count            <= retry_count + 4'd1;
                            network_data_ready_out <= 1'b1;
                            state                  <= SEND;
                        end else begin
                            tx_fail_out    <= 1'b1;
                            host_ready_out <= 1'b1;
                            state          <= IDLE;
                        end
                    end else begin
                        timeout_count <= timeout_count + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_asp_tx.sv
// Self-checking bench for asp_tx: expected frames are queued on each accepted host word
// and compared against every network_data_ready_out pulse.
module tb_asp_tx;

    logic        clk;
    logic        reset;
    logic        data_parity_ready_in;
    logic [32:0] data_parity_in;
    logic        network_ACK_in;
    logic        host_ready_out;
    logic        parity_error_out;
    logic        tx_fail_out;
    logic        network_data_ready_out;
    logic [39:0] network_data_tag_out;

    int checks;
    int passed;

    logic [39:0] exp_q[$];
    logic [39:0] last_frame;

`ifdef ASP_TX_ODD_PARITY_EN
    localparam logic        odd_target = 1'b1;
    localparam logic [32:0] plan_good  = 33'h0_00001234;
    localparam logic [32:0] plan_bad   = 33'h1_00001234;
`else
    localparam logic        odd_target = 1'b0;
    localparam logic [32:0] plan_good  = 33'h1_00001234;
    localparam logic [32:0] plan_bad   = 33'h0_00001234;
`endif

    asp_tx #(
        .data_size  (32),
        .tag_size   (8),
        .tag_value  (8'hAB),
        .ack_timeout(16),
        .max_retries(3)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .data_parity_ready_in  (data_parity_ready_in),
        .data_parity_in        (data_parity_in),
        .network_ACK_in        (network_ACK_in),
        .host_ready_out        (host_ready_out),
        .parity_error_out      (parity_error_out),
        .tx_fail_out           (tx_fail_out),
        .network_data_ready_out(network_data_ready_out),
        .network_data_tag_out  (network_data_tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Builds a host word whose parity bit is correct (good=1) or deliberately wrong (good=0).
    function automatic logic [32:0] make_word(input logic [31:0] d, input logic good);
        logic p;
        p = (^d) ^ odd_target;
        if (!good) p = ~p;
        return {p, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [32:0] word);
        data_parity_in       = word;
        data_parity_ready_in = 1'b1;
        tick();
        data_parity_ready_in = 1'b0;
    endtask

    task automatic test_reset();
        reset                = 1'b0;
        data_parity_ready_in = 1'b0;
        data_parity_in       = '0;
        network_ACK_in       = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (host_ready_out !== 1'b1) $display("[TB] FAIL reset_host_ready: observed %b expected 1", host_ready_out);
        else passed++;
        checks++;
        if (parity_error_out !== 1'b0) $display("[TB] FAIL reset_parity_error: observed %b expected 0", parity_error_out);
        else passed++;
        checks++;
        if (tx_fail_out !== 1'b0) $display("[TB] FAIL reset_tx_fail: observed %b expected 0", tx_fail_out);
        else passed++;
        checks++;
        if (network_data_ready_out !== 1'b0) $display("[TB] FAIL reset_data_ready: observed %b expected 0", network_data_ready_out);
        else passed++;
        checks++;
        if (network_data_tag_out !== 40'h0) $display("[TB] FAIL reset_tag: observed %h expected %h", network_data_tag_out, 40'h0);
        else passed++;
    endtask

    task automatic test_good_ack();
        int pulses;
        exp_q.push_back(40'h00001234AB);
        last_frame = 40'h00001234AB;
        applyStimulus(plan_good);
        pulses = 0;
        checks++;
        if (network_data_ready_out !== 1'b1) $display("[TB] FAIL ack_first_pulse: observed %b expected 1", network_data_ready_out);
        else passed++;
        checks++;
        if (network_data_tag_out !== exp_q[0]) $display("[TB] FAIL ack_frame: observed %h expected %h", network_data_tag_out, exp_q[0]);
        else passed++;
        checks++;
        if (host_ready_out !== 1'b0) $display("[TB] FAIL ack_busy: observed %b expected 0", host_ready_out);
        else passed++;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == 3) network_ACK_in = 1'b1;
            if (network_data_ready_out) pulses++;
        end
        tick();
        network_ACK_in = 1'b0;
        exp_q.pop_front();
        checks++;
        if (host_ready_out !== 1'b1) $display("[TB] FAIL ack_ready_return: observed %b expected 1", host_ready_out);
        else passed++;
        checks++;
        if (pulses !== 0 || network_data_ready_out !== 1'b0) $display("[TB] FAIL ack_extra_pulse: observed %0d expected 0", pulses + int'(network_data_ready_out));
        else passed++;
        checks++;
        if (tx_fail_out !== 1'b0 || parity_error_out !== 1'b0) $display("[TB] FAIL ack_no_err: observed %b%b expected 00", tx_fail_out, parity_error_out);
        else passed++;
    endtask

    task automatic test_parity_error();
        applyStimulus(plan_bad);
        checks++;
        if (parity_error_out !== 1'b1) $display("[TB] FAIL perr_pulse: observed %b expected 1", parity_error_out);
        else passed++;
        checks++;
        if (network_data_ready_out !== 1'b0) $display("[TB] FAIL perr_no_send: observed %b expected 0", network_data_ready_out);
        else passed++;
        checks++;
        if (host_ready_out !== 1'b1) $display("[TB] FAIL perr_ready: observed %b expected 1", host_ready_out);
        else passed++;
        checks++;
        if (network_data_tag_out !== last_frame) $display("[TB] FAIL perr_tag_held: observed %h expected %h", network_data_tag_out, last_frame);
        else passed++;
        tick();
        checks++;
        if (parity_error_out !== 1'b0 || network_data_ready_out !== 1'b0) $display("[TB] FAIL perr_one_cycle: observed %b%b expected 00", parity_error_out, network_data_ready_out);
        else passed++;
    endtask

    task automatic test_no_ack();
        int pulses;
        int last_pulse;
        int fail_at;
        logic [32:0] word;
        word = make_word(32'hDEADBEEF, 1'b1);
        exp_q.push_back({word[31:0], 8'hAB});
        last_frame = {word[31:0], 8'hAB};
        pulses     = 0;
        last_pulse = -1;
        fail_at    = -1;
        applyStimulus(word);
        for (int i = 0; i < 200; i++) begin
            if (network_data_ready_out) begin
                pulses++;
                checks++;
                if (network_data_tag_out !== exp_q[0]) $display("[TB] FAIL retry_frame: observed %h expected %h", network_data_tag_out, exp_q[0]);
                else passed++;
                if (pulses > 1) begin
                    checks++;
                    if (i - last_pulse != 17) $display("[TB] FAIL retry_spacing: observed %0d expected 17", i - last_pulse);
                    else passed++;
                end
                last_pulse = i;
            end
            if (tx_fail_out) begin
                fail_at = i;
                break;
            end
            tick();
        end
        exp_q.pop_front();
        checks++;
        if (pulses != 4) $display("[TB] FAIL retry_count: observed %0d expected 4", pulses);
        else passed++;
        checks++;
        if (fail_at != 68) $display("[TB] FAIL fail_timing: observed %0d expected 68", fail_at);
        else passed++;
        checks++;
        if (host_ready_out !== 1'b1) $display("[TB] FAIL fail_ready: observed %b expected 1", host_ready_out);
        else passed++;
        tick();
        checks++;
        if (tx_fail_out !== 1'b0 || network_data_ready_out !== 1'b0) $display("[TB] FAIL fail_one_cycle: observed %b%b expected 00", tx_fail_out, network_data_ready_out);
        else passed++;
        checks++;
        if (network_data_tag_out !== last_frame) $display("[TB] FAIL fail_tag_held: observed %h expected %h", network_data_tag_out, last_frame);
        else passed++;
    endtask

    task automatic test_ack_at_expiry();
        int pulses;
        logic [32:0] word;
        word = make_word(32'h0BADF00D, 1'b1);
        exp_q.push_back({word[31:0], 8'hAB});
        last_frame = {word[31:0], 8'hAB};
        applyStimulus(word);
        checks++;
        if (network_data_ready_out !== 1'b1 || network_data_tag_out !== exp_q[0]) $display("[TB] FAIL expiry_send: observed %b/%h expected 1/%h", network_data_ready_out, network_data_tag_out, exp_q[0]);
        else passed++;
        network_ACK_in = 1'b1;
        tick();
        network_ACK_in = 1'b0;
        checks++;
        if (host_ready_out !== 1'b0) $display("[TB] FAIL send_ack_ignored: observed %b expected 0", host_ready_out);
        else passed++;
        for (int i = 0; i < 15; i++) tick();
        network_ACK_in = 1'b1;
        checks++;
        if (host_ready_out !== 1'b0 || network_data_ready_out !== 1'b0) $display("[TB] FAIL expiry_waiting: observed %b%b expected 00", host_ready_out, network_data_ready_out);
        else passed++;
        tick();
        network_ACK_in = 1'b0;
        exp_q.pop_front();
        checks++;
        if (host_ready_out !== 1'b1) $display("[TB] FAIL expiry_ack_wins: observed %b expected 1", host_ready_out);
        else passed++;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (network_data_ready_out || tx_fail_out) pulses++;
            tick();
        end
        checks++;
        if (pulses != 0) $display("[TB] FAIL expiry_no_retransmit: observed %0d expected 0", pulses);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int pulses;
        logic [32:0] word;
        word = make_word(32'hCAFEF00D, 1'b1);
        exp_q.push_back({word[31:0], 8'hAB});
        applyStimulus(word);
        tick();
        tick();
        applyStimulus(make_word(32'h11112222, 1'b1));
        checks++;
        if (network_data_tag_out !== exp_q[0]) $display("[TB] FAIL busy_strobe_latch: observed %h expected %h", network_data_tag_out, exp_q[0]);
        else passed++;
        checks++;
        if (parity_error_out !== 1'b0 || host_ready_out !== 1'b0 || network_data_ready_out !== 1'b0) $display("[TB] FAIL busy_strobe_effect: observed %b%b%b expected 000", parity_error_out, host_ready_out, network_data_ready_out);
        else passed++;
        reset = 1'b0;
        #1;
        exp_q.pop_front();
        checks++;
        if (host_ready_out !== 1'b1 || network_data_tag_out !== 40'h0) $display("[TB] FAIL async_reset: observed %b/%h expected 1/%h", host_ready_out, network_data_tag_out, 40'h0);
        else passed++;
        checks++;
        if (tx_fail_out !== 1'b0 || network_data_ready_out !== 1'b0 || parity_error_out !== 1'b0) $display("[TB] FAIL async_reset_pulses: observed %b%b%b expected 000", tx_fail_out, network_data_ready_out, parity_error_out);
        else passed++;
        tick();
        tick();
        reset  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (network_data_ready_out || tx_fail_out) pulses++;
        end
        checks++;
        if (pulses != 0) $display("[TB] FAIL reset_frame_dropped: observed %0d expected 0", pulses);
        else passed++;
        checks++;
        if (host_ready_out !== 1'b1) $display("[TB] FAIL reset_idle_after: observed %b expected 1", host_ready_out);
        else passed++;
    endtask

    task automatic checkOutput();
        checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_empty: observed %0d expected 0", exp_q.size());
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_good_ack();
        test_parity_error();
        test_no_ack();
        test_ack_at_expiry();
        test_reset_mid_frame();
        checkOutput();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
